// File: rtl/cw_index_collector.sv
`default_nettype none
// ============================================================================
// Module   : cw_index_collector
// Brief    : Buffers one frame of constant-weight codeword indices, counts its
//            weight and drains it through a valid/read handshake.
//            Optional order check enabled by defining CW_ORDER_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cw_index_collector #(
    parameter int IDX_W = 10,
    parameter int DEPTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [IDX_W-1:0] cw_in,
    input  logic             cw_rdy_in,
    input  logic             cw_done_in,
    input  logic             rd_en,
    output logic [IDX_W-1:0] idx_out,
    output logic             idx_valid,
    output logic [CNT_W-1:0] weight,
    output logic             frame_done,
    output logic             busy,
    output logic             overflow,
    output logic             err_order
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_full_weight = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_one         = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   weight_q, weight_d;
    logic               frame_done_q, frame_done_d;
    logic               overflow_q, overflow_d;
    logic [IDX_W-1:0]   mem_q [DEPTH];
    logic               mem_we;
    logic [CNT_W-1:0]   occupancy;
`ifdef CW_ORDER_CHECK_EN
    logic               err_order_q, err_order_d;
    logic [IDX_W-1:0]   last_idx_q, last_idx_d;
`endif

    // Pointers carry one extra wrap bit so a full buffer is distinct from empty;
    // only the low PTR_W bits address the array.
    assign occupancy = wr_ptr_q - rd_ptr_q;
    assign idx_valid = (state_q == ST_DRAIN) && (occupancy != '0);
    assign idx_out   = idx_valid ? mem_q[rd_ptr_q[PTR_W-1:0]] : '0;
    assign weight    = weight_q;
    assign frame_done = frame_done_q;
    assign busy      = (state_q != ST_IDLE);
    assign overflow  = overflow_q;
`ifdef CW_ORDER_CHECK_EN
    assign err_order = err_order_q;
`else
    assign err_order = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        weight_d     = weight_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;
        mem_we       = 1'b0;
`ifdef CW_ORDER_CHECK_EN
        err_order_d  = err_order_q;
        last_idx_d   = last_idx_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (cw_rdy_in) begin
                    mem_we     = 1'b1;
                    wr_ptr_d   = wr_ptr_q + c_one;
                    weight_d   = c_one;
                    overflow_d = 1'b0;
`ifdef CW_ORDER_CHECK_EN
                    err_order_d = 1'b0;
                    last_idx_d  = cw_in;
`endif
                    state_d    = cw_done_in ? ST_DRAIN : ST_COLLECT;
                end else if (cw_done_in) begin
                    weight_d     = '0;
                    frame_done_d = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (cw_rdy_in) begin
                    if (weight_q == c_full_weight) begin
                        overflow_d = 1'b1;
                    end else begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + c_one;
                        weight_d = weight_q + c_one;
`ifdef CW_ORDER_CHECK_EN
                        if (cw_in <= last_idx_q) err_order_d = 1'b1;
                        last_idx_d = cw_in;
`endif
                    end
                end
                if (cw_done_in) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (cw_rdy_in) overflow_d = 1'b1;
                if (rd_en && idx_valid) begin
                    rd_ptr_d = rd_ptr_q + c_one;
                    if (occupancy == c_one) begin
                        frame_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            weight_q     <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
`ifdef CW_ORDER_CHECK_EN
            err_order_q  <= 1'b0;
            last_idx_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            weight_q     <= weight_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
`ifdef CW_ORDER_CHECK_EN
            err_order_q  <= err_order_d;
            last_idx_q   <= last_idx_d;
`endif
        end
    end

    // Data array needs no reset: entries are only visible while idx_valid.
    always_ff @(posedge clk) begin
        if (mem_we && !rst_b) mem_q[wr_ptr_q[PTR_W-1:0]] <= cw_in;
    end

endmodule
`default_nettype wire

// File: tb/tb_cw_index_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_cw_index_collector
// Brief    : Directed scoreboard bench for cw_index_collector.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cw_index_collector;

    localparam int IDX_W = 10;
    localparam int DEPTH = 64;
    localparam int CNT_W = 7;
`ifdef CW_ORDER_CHECK_EN
    localparam logic ORDER_EN = 1'b1;
`else
    localparam logic ORDER_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_b = 1'b1;
    logic [IDX_W-1:0] cw_in = '0;
    logic             cw_rdy_in = 1'b0;
    logic             cw_done_in = 1'b0;
    logic             rd_en = 1'b0;
    logic [IDX_W-1:0] idx_out;
    logic             idx_valid;
    logic [CNT_W-1:0] weight;
    logic             frame_done;
    logic             busy;
    logic             overflow;
    logic             err_order;

    int tests = 0;
    int fails = 0;
    logic [IDX_W-1:0] exp_q[$];

    cw_index_collector #(.IDX_W(IDX_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .cw_in      (cw_in),
        .cw_rdy_in  (cw_rdy_in),
        .cw_done_in (cw_done_in),
        .rd_en      (rd_en),
        .idx_out    (idx_out),
        .idx_valid  (idx_valid),
        .weight     (weight),
        .frame_done (frame_done),
        .busy       (busy),
        .overflow   (overflow),
        .err_order  (err_order)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [IDX_W-1:0] idx, input bit done, input bit keep);
        cw_in      = idx;
        cw_rdy_in  = 1'b1;
        cw_done_in = done;
        if (keep) exp_q.push_back(idx);
        tick();
        cw_rdy_in  = 1'b0;
        cw_done_in = 1'b0;
    endtask

    task automatic end_frame();
        cw_done_in = 1'b1;
        tick();
        cw_done_in = 1'b0;
    endtask

    // Pops the scoreboard as the DUT presents indices; in toggle mode every
    // other valid cycle is held off to check idx_out stays on the same entry.
    task automatic drain(input string tag, input bit toggle, input int exp_weight);
        int fd    = 0;
        int guard = 0;
        int tail  = 0;
        bit phase = 1'b1;
        while (tail < 3 && guard < 400) begin
            if (frame_done) fd++;
            rd_en = 1'b0;
            if (exp_q.size() == 0) begin
                tail++;
                if (tail == 1) chk({tag, " valid_after_empty"}, 32'(idx_valid), 32'd0);
            end else if (idx_valid) begin
                chk({tag, " idx"}, 32'(idx_out), 32'(exp_q[0]));
                if (!toggle || phase) begin
                    rd_en = 1'b1;
                    void'(exp_q.pop_front());
                end
                phase = ~phase;
            end
            tick();
            guard++;
        end
        rd_en = 1'b0;
        chk({tag, " drain_in_time"}, 32'(guard < 400), 32'd1);
        chk({tag, " frame_done_count"}, 32'(fd), 32'd1);
        chk({tag, " weight"}, 32'(weight), 32'(exp_weight));
        chk({tag, " busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IDX_W-1:0] frame8 [8];
        frame8 = '{10'd3, 10'd17, 10'd40, 10'd99, 10'd250, 10'd511, 10'd800, 10'd1023};

        // Reset state
        repeat (3) tick();
        rst_b = 1'b0;
        tick();
        chk("rst idx_valid", 32'(idx_valid), 32'd0);
        chk("rst idx_out", 32'(idx_out), 32'd0);
        chk("rst weight", 32'(weight), 32'd0);
        chk("rst frame_done", 32'(frame_done), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst overflow", 32'(overflow), 32'd0);
        chk("rst err_order", 32'(err_order), 32'd0);

        // T1: reset mid-COLLECT
        strobe(10'd7, 1'b0, 1'b0);
        strobe(10'd8, 1'b0, 1'b0);
        strobe(10'd9, 1'b0, 1'b0);
        chk("T1 busy_before", 32'(busy), 32'd1);
        chk("T1 weight_before", 32'(weight), 32'd3);
        rst_b = 1'b1;
        repeat (3) tick();
        chk("T1 busy", 32'(busy), 32'd0);
        chk("T1 weight", 32'(weight), 32'd0);
        chk("T1 idx_valid", 32'(idx_valid), 32'd0);
        chk("T1 idx_out", 32'(idx_out), 32'd0);
        chk("T1 frame_done", 32'(frame_done), 32'd0);
        chk("T1 overflow", 32'(overflow), 32'd0);
        chk("T1 err_order", 32'(err_order), 32'd0);
        rst_b = 1'b0;
        exp_q.delete();

        // T2: normal frame, continuous read
        foreach (frame8[i]) strobe(frame8[i], 1'b0, 1'b1);
        chk("T2 weight", 32'(weight), 32'd8);
        chk("T2 valid_in_collect", 32'(idx_valid), 32'd0);
        end_frame();
        chk("T2 valid_latency", 32'(idx_valid), 32'd1);
        drain("T2", 1'b0, 8);
        chk("T2 overflow", 32'(overflow), 32'd0);

        // T3: backpressure
        foreach (frame8[i]) strobe(frame8[i], 1'b0, 1'b1);
        end_frame();
        drain("T3", 1'b1, 8);
        chk("T3 overflow", 32'(overflow), 32'd0);

        // T4: overflow with DEPTH+1 strobes, then one strobe in DRAIN
        for (int i = 0; i < DEPTH + 1; i++)
            strobe(IDX_W'((i * 13 + 1) % 1024), 1'b0, i < DEPTH);
        chk("T4 weight_sat", 32'(weight), 32'(DEPTH));
        chk("T4 overflow", 32'(overflow), 32'd1);
        end_frame();
        strobe(10'd555, 1'b0, 1'b0);
        chk("T4 overflow_drain", 32'(overflow), 32'd1);
        drain("T4", 1'b0, DEPTH);
        chk("T4 overflow_after", 32'(overflow), 32'd1);

        // T5a: empty frame
        end_frame();
        chk("T5a frame_done", 32'(frame_done), 32'd1);
        chk("T5a weight", 32'(weight), 32'd0);
        chk("T5a busy", 32'(busy), 32'd0);
        chk("T5a idx_valid", 32'(idx_valid), 32'd0);
        tick();
        chk("T5a frame_done_pulse", 32'(frame_done), 32'd0);

        // T5b: last strobe coincides with cw_done_in
        strobe(10'd100, 1'b0, 1'b1);
        chk("T5b overflow_cleared", 32'(overflow), 32'd0);
        strobe(10'd200, 1'b0, 1'b1);
        strobe(10'd300, 1'b1, 1'b1);
        chk("T5b weight", 32'(weight), 32'd3);
        chk("T5b valid_latency", 32'(idx_valid), 32'd1);
        drain("T5b", 1'b0, 3);

        // T5c: single-index frame straight from IDLE
        strobe(10'd77, 1'b1, 1'b1);
        chk("T5c busy", 32'(busy), 32'd1);
        chk("T5c weight", 32'(weight), 32'd1);
        drain("T5c", 1'b0, 1);

        // T6: order check
        strobe(10'd5, 1'b0, 1'b1);
        strobe(10'd9, 1'b0, 1'b1);
        chk("T6 err_before", 32'(err_order), 32'd0);
        strobe(10'd9, 1'b0, 1'b1);
        chk("T6 err_third", 32'(err_order), 32'(ORDER_EN));
        strobe(10'd2, 1'b0, 1'b1);
        end_frame();
        drain("T6", 1'b0, 4);
        chk("T6 err_sticky", 32'(err_order), 32'(ORDER_EN));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
